// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch front end.
// Optional misaligned-fetch trap is enabled with FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_HOLD,
    S_TRAP
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
  localparam logic [1:0] PC_SRC_BR   = 2'b01;
  localparam logic [1:0] PC_SRC_JALR = 2'b10;

  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int F7_B6   = 30;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: sequential, pc-relative branch/jal, or jalr target.
// Purely combinational; flags targets that are not word aligned.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_pc_src,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misaligned
);

  logic [XLEN-1:0] jalr_sum;

  assign jalr_sum = i_rs1 + i_imm;

  always_comb begin
    o_next_pc = i_pc + XLEN'(4);
    unique case (1'b1)
      (i_pc_src == PC_SRC_BR):
        o_next_pc = i_pc + i_imm;
      (i_pc_src == PC_SRC_JALR):
        o_next_pc = {jalr_sum[XLEN-1:1], 1'b0};
      default:
        o_next_pc = i_pc + XLEN'(4);
    endcase
  end

  assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner and single-outstanding instruction fetcher for the RV32 core.
// Define FETCH_MISALIGN_TRAP_EN to trap on misaligned targets (o_misaligned).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_req_valid,
  output logic [XLEN-1:0] o_req_addr,
  input  logic            i_req_ready,
  input  logic            i_rsp_valid,
  input  logic [31:0]     i_rsp_data,
  output logic            o_instr_valid,
  output logic [31:0]     o_instr,
  output logic [6:0]      o_opcode,
  output logic [2:0]      o_f3,
  output logic            o_f7_bit6,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4,
  input  logic            i_instr_ack,
  input  logic [1:0]      i_pc_src,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  output logic [31:0]     o_instret
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            o_misaligned
`endif
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     instret_q, instret_d;
  logic            req_valid_q, req_valid_d;
  logic            instr_valid_q, instr_valid_d;
  logic            misaligned_q, misaligned_d;

  logic [XLEN-1:0] npc_raw;
  logic [XLEN-1:0] npc;
  logic            npc_mis;

  next_pc_calc #(.XLEN(XLEN)) u_next_pc (
    .i_pc        (pc_q),
    .i_pc_src    (i_pc_src),
    .i_imm       (i_imm),
    .i_rs1       (i_rs1),
    .o_next_pc   (npc_raw),
    .o_misaligned(npc_mis)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  assign npc = npc_raw;
`else
  // Without the trap, low bits are forced clear so fetch stays word aligned.
  assign npc = {npc_raw[XLEN-1:2],
                npc_mis ? 2'b00 : npc_raw[1:0]};
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instret_d     = instret_q;
    req_valid_d   = req_valid_q;
    instr_valid_d = instr_valid_q;
    misaligned_d  = misaligned_q;
    unique case (state_q)
      S_IDLE: begin
        state_d     = S_REQ;
        req_valid_d = 1'b1;
      end
      S_REQ: begin
        if (i_req_ready) begin
          state_d     = S_RSP;
          req_valid_d = 1'b0;
        end
      end
      S_RSP: begin
        if (i_rsp_valid) begin
          state_d       = S_HOLD;
          instr_d       = i_rsp_data;
          instr_valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_instr_ack) begin
          pc_d          = npc;
          instret_d     = instret_q + 32'd1;
          instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (npc_mis) begin
            state_d      = S_TRAP;
            misaligned_d = 1'b1;
          end else begin
            state_d     = S_REQ;
            req_valid_d = 1'b1;
          end
`else
          state_d     = S_REQ;
          req_valid_d = 1'b1;
`endif
        end
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= XLEN'(RESET_PC);
      instr_q       <= '0;
      instret_q     <= '0;
      req_valid_q   <= 1'b0;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instret_q     <= instret_d;
      req_valid_q   <= req_valid_d;
      instr_valid_q <= instr_valid_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign o_req_valid   = req_valid_q;
  assign o_req_addr    = pc_q;
  assign o_instr_valid = instr_valid_q;
  assign o_instr       = instr_q;
  assign o_opcode      = instr_q[OPC_MSB:OPC_LSB];
  assign o_f3          = instr_q[F3_MSB:F3_LSB];
  assign o_f7_bit6     = instr_q[F7_B6];
  assign o_pc          = pc_q;
  assign o_pc_plus4    = pc_q + XLEN'(4);
  assign o_instret     = instret_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign o_misaligned = misaligned_q;
`else
  logic unused_mis;
  assign unused_mis = misaligned_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch handshake, next-PC modes,
// stall/glitch handling, mid-transaction reset and misaligned jalr.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        f7_bit6;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ack;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic [31:0] instret;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0), .XLEN(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_req_valid  (req_valid),
    .o_req_addr   (req_addr),
    .i_req_ready  (req_ready),
    .i_rsp_valid  (rsp_valid),
    .i_rsp_data   (rsp_data),
    .o_instr_valid(instr_valid),
    .o_instr      (instr),
    .o_opcode     (opcode),
    .o_f3         (f3),
    .o_f7_bit6    (f7_bit6),
    .o_pc         (pc),
    .o_pc_plus4   (pc_plus4),
    .i_instr_ack  (instr_ack),
    .i_pc_src     (pc_src),
    .i_imm        (imm),
    .i_rs1        (rs1),
    .o_instret    (instret)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .o_misaligned (misaligned)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h",
               tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, accept it, answer one cycle later.
  task automatic fetch(input logic [31:0] word);
    int n = 0;
    while (!req_valid && n < 20) begin
      step();
      n++;
    end
    check("req_valid_wait", {31'b0, req_valid}, 32'd1);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = word;
    step();
    rsp_valid = 1'b0;
    check("instr_valid", {31'b0, instr_valid}, 32'd1);
    check("instr", instr, word);
  endtask

  task automatic retire(input logic [1:0]  src,
                        input logic [31:0] i_v,
                        input logic [31:0] r_v);
    instr_ack = 1'b1;
    pc_src    = src;
    imm       = i_v;
    rs1       = r_v;
    step();
    instr_ack = 1'b0;
    pc_src    = 2'b00;
    imm       = 32'hDEAD_0001;
    rs1       = 32'hDEAD_0003;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    instr_ack = 1'b0;
    pc_src    = 2'b00;
    imm       = '0;
    rs1       = '0;
    step();
    step();
    check("rst_req_valid", {31'b0, req_valid}, 32'd0);
    check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_addr", req_addr, 32'h0);

    rst_n = 1'b1;
    step();
    check("first_req_valid", {31'b0, req_valid}, 32'd1);
    check("first_addr", req_addr, 32'h0);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    check("rsp_wait_valid", {31'b0, instr_valid}, 32'd0);
    check("rsp_wait_req", {31'b0, req_valid}, 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = 32'h0050_0093;
    step();
    rsp_valid = 1'b0;
    check("lat_instr_valid", {31'b0, instr_valid}, 32'd1);
    check("opcode", {25'b0, opcode}, 32'h13);
    check("f3", {29'b0, f3}, 32'h0);
    check("pc0", pc, 32'h0);
    check("pc_plus4_0", pc_plus4, 32'h4);

    retire(2'b00, 32'h0, 32'h0);
    check("seq_addr_4", req_addr, 32'h4);
    check("instret_1", instret, 32'd1);
    fetch(32'h0000_0013);
    retire(2'b00, 32'h0, 32'h0);
    fetch(32'h0000_0013);
    retire(2'b00, 32'h0, 32'h0);
    fetch(32'h0000_0013);
    retire(2'b00, 32'h0, 32'h0);

    fetch(32'h0020_9113);
    check("pc_10", pc, 32'h10);
    check("f3_1", {29'b0, f3}, 32'h1);
    retire(2'b00, 32'h0, 32'h0);
    check("seq_addr_14", req_addr, 32'h14);
    check("instret_5", instret, 32'd5);

    fetch(32'h0000_006F);
    retire(2'b01, 32'h0000_000C, 32'h0);
    check("br_addr_20", req_addr, 32'h20);
    fetch(32'hFE00_0CE3);
    retire(2'b01, 32'hFFFF_FFF8, 32'h0);
    check("br_back_18", req_addr, 32'h18);
    fetch(32'h0040_8067);
    retire(2'b10, 32'h0000_0004, 32'h0000_0101);
    check("jalr_104", req_addr, 32'h104);
    fetch(32'h0000_0013);
    retire(2'b11, 32'h0000_0100, 32'h0000_0200);
    check("rsvd_108", req_addr, 32'h108);
    check("instret_9", instret, 32'd9);

    // Stall with stray response and stray ack while requesting.
    for (int i = 0; i < 3; i++) begin
      rsp_valid = (i == 1);
      rsp_data  = 32'hDEAD_BEEF;
      instr_ack = 1'b1;
      step();
      check("stall_addr", req_addr, 32'h108);
      check("stall_valid", {31'b0, req_valid}, 32'd1);
    end
    rsp_valid = 1'b0;
    instr_ack = 1'b0;
    check("stray_ack_instret", instret, 32'd9);
    check("stray_rsp_instr", instr, 32'h0000_0013);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    step();
    check("late_rsp_wait", {31'b0, instr_valid}, 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = 32'h4000_0033;
    step();
    rsp_valid = 1'b0;
    check("post_accept_instr", instr, 32'h4000_0033);
    check("f7_bit6", {31'b0, f7_bit6}, 32'd1);
    check("opcode_33", {25'b0, opcode}, 32'h33);

    retire(2'b10, 32'h0, 32'h0000_0040);
    check("jalr_40", req_addr, 32'h40);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", {31'b0, req_valid}, 32'd0);
    check("midrst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("midrst_addr", req_addr, 32'h0);
    check("midrst_instret", instret, 32'd0);
    rst_n     = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'hBAD0_BAD0;
    step();
    rsp_valid = 1'b0;
    check("post_rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    check("post_rst_req", {31'b0, req_valid}, 32'd1);
    check("post_rst_addr", req_addr, 32'h0);
    check("post_rst_instr", instr, 32'h0);

    fetch(32'h0000_8067);
    retire(2'b10, 32'h0, 32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("trap_flag", {31'b0, misaligned}, 32'd1);
    check("trap_pc", pc, 32'h102);
    for (int i = 0; i < 4; i++) begin
      step();
      check("trap_no_req", {31'b0, req_valid}, 32'd0);
      check("trap_no_instr", {31'b0, instr_valid}, 32'd0);
    end
    check("trap_sticky", {31'b0, misaligned}, 32'd1);
`else
    check("noalign_addr", req_addr, 32'h100);
    check("noalign_req", {31'b0, req_valid}, 32'd1);
    fetch(32'h0000_0013);
    check("noalign_pc", pc, 32'h100);
`endif
    check("final_instret", instret, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
